// File: rtl/crypto_wallet_io_pio.sv
// Key/switch/LED parallel I/O block for the crypto_wallet system.
// Raw key and switch pins are synchronised, debounced and edge-captured.
// Captured edges that are enabled in the mask drive a level interrupt.
// The LED register can be written directly or through set/clear aliases.
module crypto_wallet_io_pio #(
    parameter int                 N_KEY      = 2,
    parameter int                 N_SW       = 4,
    parameter int                 N_LED      = 8,
    parameter int                 DEB_CYCLES = 50000,
    parameter int                 KEY_EDGE   = 0,
    parameter int                 SW_EDGE    = 2,
    parameter logic [N_LED-1:0]   LED_RESET  = '0
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [2:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    input  logic [N_KEY-1:0]      key_in,
    input  logic [N_SW-1:0]       sw_in,
    output logic [N_LED-1:0]      led_out,
    output logic                  irq
);

    localparam int N_IN = N_KEY + N_SW;
    localparam int CW   = $clog2(DEB_CYCLES + 3);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] ARM_DONE = CW'(DEB_CYCLES + 2);
    localparam logic [31:0] PARAMS_WORD = {(DEB_CYCLES >= 2) ? 8'd1 : 8'd0,
                                           8'(N_LED), 8'(N_SW), 8'(N_KEY)};

    localparam logic [2:0] A_DATA_IN = 3'd0;
    localparam logic [2:0] A_LED     = 3'd1;
    localparam logic [2:0] A_LED_SET = 3'd2;
    localparam logic [2:0] A_LED_CLR = 3'd3;
    localparam logic [2:0] A_MASK    = 3'd4;
    localparam logic [2:0] A_EDGE    = 3'd5;
    localparam logic [2:0] A_PARAMS  = 3'd6;

    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync_p0;
    logic [N_IN-1:0]  sync_p1;
    logic [N_IN-1:0]  deb;
    logic [CW-1:0]    deb_cnt [N_IN];
    logic [N_IN-1:0]  prev;
    logic [N_IN-1:0]  edges;
    logic [N_IN-1:0]  w1c;
    logic [N_IN-1:0]  edge_cap;
    logic [N_IN-1:0]  edge_cap_next;
    logic [N_IN-1:0]  mask;
    logic [N_IN-1:0]  mask_next;
    logic [N_LED-1:0] led_next;
    logic [CW-1:0]    arm_cnt;
    logic             armed;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Keys occupy the low bits, switches sit directly above them.
    assign raw          = {sw_in, key_in};
    assign unused_wdata = ^avs_writedata;

    // Edge qualification for one bit: 0 falling, 1 rising, anything else both.
    function automatic logic edge_of(input int mode, input logic p, input logic d);
        case (mode)
            0:       edge_of = p & ~d;
            1:       edge_of = ~p & d;
            default: edge_of = p ^ d;
        endcase
    endfunction

    // Two-flop synchroniser for every input pin.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Per-bit debounce: the synced value must differ from the debounced value for DEB_CYCLES cycles.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            deb <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Arming timer; armed is registered one cycle after the count saturates so the
    // edge produced by the first debounce settle after reset is never captured.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + 1'b1;
            armed <= (arm_cnt == ARM_DONE);
        end
    end

    // Next-state for edge capture, mask and LEDs; a new edge overrides a same-cycle W1C.
    always_comb begin
        edges = '0;
        for (int i = 0; i < N_IN; i++) begin
            edges[i] = armed & edge_of((i < N_KEY) ? KEY_EDGE : SW_EDGE, prev[i], deb[i]);
        end
        w1c           = (avs_write && avs_address == A_EDGE) ? avs_writedata[N_IN-1:0] : '0;
        edge_cap_next = (edge_cap & ~w1c) | edges;
        mask_next     = (avs_write && avs_address == A_MASK) ? avs_writedata[N_IN-1:0] : mask;
        led_next      = led_out;
        if (avs_write) begin
            case (avs_address)
                A_LED:     led_next = avs_writedata[N_LED-1:0];
                A_LED_SET: led_next = led_out | avs_writedata[N_LED-1:0];
                A_LED_CLR: led_next = led_out & ~avs_writedata[N_LED-1:0];
                default:   led_next = led_out;
            endcase
        end
    end

    // Control state: previous debounced value, captured edges, mask, LEDs and interrupt.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            prev     <= '0;
            edge_cap <= '0;
            mask     <= '0;
            led_out  <= LED_RESET;
            irq      <= 1'b0;
        end else begin
            prev     <= deb;
            edge_cap <= edge_cap_next;
            mask     <= mask_next;
            led_out  <= led_next;
            irq      <= |(edge_cap_next & mask_next);
        end
    end

    // Read mux built from current (pre-write) register values.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_DATA_IN:                   rd_mux[N_IN-1:0]  = deb;
            A_LED, A_LED_SET, A_LED_CLR: rd_mux[N_LED-1:0] = led_out;
            A_MASK:                      rd_mux[N_IN-1:0]  = mask;
            A_EDGE:                      rd_mux[N_IN-1:0]  = edge_cap;
            A_PARAMS:                    rd_mux            = PARAMS_WORD;
            default:                     rd_mux            = '0;
        endcase
    end

    // Registered read data with fixed one-cycle latency; zero when no read is issued.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_crypto_wallet_io_pio.sv
// Directed testbench for crypto_wallet_io_pio with a short debounce window.
module tb_crypto_wallet_io_pio;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [1:0]  key_in;
    logic [3:0]  sw_in;
    logic [7:0]  led_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    crypto_wallet_io_pio #(
        .N_KEY(2), .N_SW(4), .N_LED(8), .DEB_CYCLES(4)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .key_in(key_in),
        .sw_in(sw_in),
        .led_out(led_out),
        .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        check(tag, avs_readdata, exp);
    endtask

    initial begin
        reset_reset   = 1'b1;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        key_in        = 2'b11;
        sw_in         = 4'b0000;
        tick(3);
        check("rst_led", {24'd0, led_out}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_rdata", avs_readdata, 32'h0);

        // Keys held high through reset: debounced value appears on the sixth edge.
        reset_reset = 1'b0;
        tick(5);
        read_check("data_in_edge6", 3'd0, 32'h0);
        read_check("data_in_settled", 3'd0, 32'h3);
        tick(3);
        read_check("edge_cap_after_arm", 3'd5, 32'h0);
        check("irq_after_arm", {31'd0, irq}, 32'h0);
        read_check("params", 3'd6, 32'h01080402);
        read_check("addr7", 3'd7, 32'h0);
        bus_write(3'd0, 32'hFFFF_FFFF);
        read_check("data_in_ro", 3'd0, 32'h3);

        // Clean falling edge on key 0 with mask bit 0 enabled.
        bus_write(3'd4, 32'h1);
        read_check("mask_rb", 3'd4, 32'h1);
        key_in = 2'b10;
        tick(6);
        check("irq_before_cap", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_after_cap", {31'd0, irq}, 32'h1);
        read_check("edge_cap_key0", 3'd5, 32'h1);
        bus_write(3'd5, 32'h1);
        check("irq_after_w1c", {31'd0, irq}, 32'h0);
        read_check("edge_cap_cleared", 3'd5, 32'h0);

        // Key 1 bounces every two cycles, then settles low: one falling edge.
        for (int i = 0; i < 10; i++) begin
            key_in[1] = ~key_in[1];
            tick(2);
        end
        key_in[1] = 1'b0;
        tick(10);
        read_check("bounce_one_edge", 3'd5, 32'h2);
        check("bounce_irq_masked", {31'd0, irq}, 32'h0);
        bus_write(3'd5, 32'h2);
        read_check("bounce_cleared", 3'd5, 32'h0);

        // LED direct, set and clear aliases.
        bus_write(3'd1, 32'hF0);
        bus_write(3'd2, 32'h03);
        bus_write(3'd3, 32'h10);
        check("led_pins", {24'd0, led_out}, 32'hE3);
        read_check("led_rb", 3'd1, 32'hE3);
        read_check("led_set_alias_rb", 3'd2, 32'hE3);

        // Read and write of the LED register in the same cycle.
        avs_address   = 3'd1;
        avs_writedata = 32'h55;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        check("rw_same_read", avs_readdata, 32'hE3);
        check("rw_same_led", {24'd0, led_out}, 32'h55);

        // Switch 0 (bit 2): rising edge captured, then falling edge collides with W1C.
        bus_write(3'd4, 32'h5);
        sw_in = 4'b0001;
        tick(7);
        read_check("sw0_rise", 3'd5, 32'h4);
        check("sw0_irq", {31'd0, irq}, 32'h1);
        sw_in = 4'b0000;
        tick(6);
        bus_write(3'd5, 32'h4);
        read_check("w1c_vs_edge", 3'd5, 32'h4);
        check("w1c_vs_edge_irq", {31'd0, irq}, 32'h1);
        bus_write(3'd4, 32'h1);
        check("mask_drop_irq", {31'd0, irq}, 32'h0);
        bus_write(3'd5, 32'h4);
        read_check("sw0_cleared", 3'd5, 32'h0);

        // Reset mid-debounce of switch 3.
        sw_in = 4'b1000;
        tick(3);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        check("rst2_led", {24'd0, led_out}, 32'h0);
        check("rst2_irq", {31'd0, irq}, 32'h0);
        read_check("rst2_mask", 3'd4, 32'h0);
        read_check("rst2_edge_cap", 3'd5, 32'h0);
        tick(15);
        read_check("rearm_no_edge", 3'd5, 32'h0);
        read_check("rearm_data_in", 3'd0, 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
